// File: rtl/mul_arb2.sv
// Two-requester shared 32x32 signed low-word multiplier with a two-stage pipeline.
// Build option MUL_ARB_FIXED_PRIO_EN: strict priority to requester 0 instead of round-robin.
module mul_arb2 #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_product,

    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic                   s1_v;
    logic [DW-1:0]          s1_a;
    logic [DW-1:0]          s1_b;
    logic [TAG_W-1:0]       s1_tag;
    logic                   s1_id;
    logic                   s2_v;

    logic                   s1_take;
    logic                   s2_take;
    logic                   grant0;
    logic                   grant1;
    logic                   xfer0;
    logic                   xfer1;
    logic                   s1_v_d;
    logic                   s2_v_d;
    logic signed [DW-1:0]   mul_c;

    assign rsp_valid = s2_v;

    // Shared multiplier: low word of a signed product equals the wrapped 32-bit product.
    assign mul_c = $signed(s1_a) * $signed(s1_b);

`ifdef MUL_ARB_FIXED_PRIO_EN
    assign grant0 = 1'b1;
    assign grant1 = !req0_valid;
`else
    logic last_grant;

    // Each grant looks only at the other requester's valid, so ready never loops back on its own valid.
    assign grant0 = !req1_valid || last_grant;
    assign grant1 = !req0_valid || !last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (xfer0) begin
            last_grant <= 1'b0;
        end else if (xfer1) begin
            last_grant <= 1'b1;
        end
    end
`endif

    // Pipeline flow control and handshakes.
    always_comb begin
        s2_take    = !s2_v || rsp_ready;
        s1_take    = !s1_v || s2_take;
        req0_ready = !rst && s1_take && grant0;
        req1_ready = !rst && s1_take && grant1;
        xfer0      = req0_valid && req0_ready;
        xfer1      = req1_valid && req1_ready;
        s1_v_d     = s1_take ? (xfer0 || xfer1) : s1_v;
        s2_v_d     = s2_take ? s1_v : s2_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v        <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_tag      <= '0;
            s1_id       <= 1'b0;
            s2_v        <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_tag     <= '0;
            rsp_product <= '0;
            busy        <= 1'b0;
            op_count    <= '0;
        end else begin
            s1_v <= s1_v_d;
            s2_v <= s2_v_d;
            busy <= s1_v_d || s2_v_d;

            if (xfer0) begin
                s1_a   <= req0_a;
                s1_b   <= req0_b;
                s1_tag <= req0_tag;
                s1_id  <= 1'b0;
            end else if (xfer1) begin
                s1_a   <= req1_a;
                s1_b   <= req1_b;
                s1_tag <= req1_tag;
                s1_id  <= 1'b1;
            end

            if (s2_take && s1_v) begin
                rsp_product <= DW'(mul_c);
                rsp_tag     <= s1_tag;
                rsp_id      <= s1_id;
            end

            if (s2_v && rsp_ready) begin
                op_count <= op_count + CW'(1);
            end
        end
    end

endmodule

// File: doc/mul_arb2.md
MUL_ARB2 -- requirements
Module: mul_arb2

Interface
REQ-001 Parameter TAG_W, default 4: width of the per-request tag returned with each result.
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  signed multiplicand and multiplier, requester 0.
REQ-007 req0_tag  input  TAG_W  requester 0 tag.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_tag  same as REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  requester index that issued the result.
REQ-012 rsp_tag  output  TAG_W  tag of the issuing request.
REQ-013 rsp_product  output  32  signed low 32 bits of a*b.
REQ-014 busy  output  1  high when any operation is in flight (s1_v or s2_v).
REQ-015 op_count  output  16  count of completed responses (rsp_valid && rsp_ready), wraps 0xFFFF->0x0000.

Function
REQ-016 The block SHALL share one internal combinational 32x32 signed low-word multiplier between two requesters through a two-stage pipeline: S1 operand register, S2 result register.
REQ-017 A transfer on requester k SHALL occur when reqk_valid && reqk_ready at a rising clk edge; at most one requester is granted per cycle.
REQ-018 S2 SHALL advance (s2_take) when !s2_v || rsp_ready; S1 SHALL accept a new op (s1_take) when !s1_v || s2_take.
REQ-019 reqk_ready SHALL be combinational: s1_take && grant_k; ready SHALL NOT depend on reqk_valid of the same requester (no valid-to-ready self-loop), only on the other's valid for arbitration.
REQ-020 Arbitration (default): round-robin; if both valid, grant the requester not granted last; if one valid, grant it; last-grant pointer updates only on an actual transfer.
REQ-021 S1 SHALL capture a, b, tag, id on transfer; S2 SHALL capture product = low 32 bits of S1 a*b (signed, two's complement wrap), plus tag and id, when s2_take && s1_v.
REQ-022 Latency: op accepted at edge N SHALL present rsp_valid after edge N+1 with rsp_ready held high; sustained throughput one op per cycle.
REQ-023 While rsp_valid && !rsp_ready, rsp_product, rsp_tag, rsp_id SHALL hold stable; S1 holds; both req ready low once S1 is full.
REQ-024 Results SHALL return in acceptance order; no op dropped or duplicated.
REQ-025 Simultaneous rsp handshake and new acceptance in same cycle SHALL both complete (full pipeline flow-through).
REQ-026 Edge operands: 0x80000000*0xFFFFFFFF SHALL yield 0x80000000; x*0 SHALL yield 0.

Reset
REQ-027 On rst high, asynchronously: s1_v=0, s2_v=0, rsp_valid=0, busy=0, op_count=0, last-grant pointer=1 (requester 0 wins first contention); data registers SHALL reset to 0.
REQ-028 reqk_ready SHALL be 0 while rst is high.
REQ-029 Reset mid-operation SHALL discard all in-flight ops; no response for them is ever produced.

Configuration
REQ-030 Macro MUL_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL have strict priority over requester 1 and the last-grant pointer is absent; when undefined, round-robin per REQ-020.

Verification
REQ-031 Single op: req0 a=7, b=-3, tag=5, rsp_ready=1 -> two cycles later rsp_valid=1, product=0xFFFFFFEB, id=0, tag=5, op_count=1.
REQ-032 Contention: both valid continuously 4 cycles, rsp_ready=1 -> grants 0,1,0,1 (round-robin) or 0,0,0,0 (MUL_ARB_FIXED_PRIO_EN); responses in same order.
REQ-033 Backpressure: issue 3 ops with rsp_ready=0 -> exactly 2 accepted, third ready low, rsp outputs stable; release rsp_ready -> all 3 results in order, no loss.
REQ-034 Boundary: a=0x80000000, b=0xFFFFFFFF -> product 0x80000000; a=0x00010000, b=0x00010000 -> 0x00000000.
REQ-035 Reset mid-flight: accept op, assert rst next cycle -> rsp_valid never asserts for it, busy=0, op_count=0.
REQ-036 Counter wrap: preload via 65536 completed ops -> op_count returns to 0x0000.
